uart_tx_fifo_reader: RTL and testbench
======================================

// Module: uart_tx_fifo_reader
// PURPOSE
//  Transmit-side consumer of the UART TX FIFO. Pops bytes from the FIFO and serialises each one
//  onto the tx line: start bit, DBIT data bits LSB first, optional parity bit, stop bit(s).
//  Bit timing comes from an external 16x-oversampling baud tick (s_tick).
//  Sits between the TX FIFO read port and the UART pin; the APB side only sees the FIFO.
// PARAMETERS
//  DBIT     8   data bits per frame (5..8)
//  SB_TICK  16  s_tick count for the stop period (16=1, 24=1.5, 32=2 stop bits)
// PORTS
//  clk           in   1     system clock
//  reset_n       in   1     asynchronous active-low reset
//  s_tick        in   1     baud tick, one clk wide, 16 per bit period
//  fifo_empty    in   1     TX FIFO empty flag
//  fifo_r_data   in   DBIT  FIFO head word; valid whenever fifo_empty=0 (first-word fall-through)
//  fifo_rd       out  1     pop strobe, one clk wide
//  par_odd       in   1     parity select, 1=odd 0=even (port exists only with UART_TX_PARITY_EN)
//  tx            out  1     serial line, registered, idles high
//  tx_busy       out  1     high while a frame is in progress (any state except IDLE)
//  tx_done_tick  out  1     one-clk pulse at end of stop period
// BEHAVIOUR
//  - Clock and reset: one clock clk. reset_n is asynchronous and active-low.
//  - Reset values: tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, state=IDLE, counters=0.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: when fifo_empty=0, in that same clk:
//      - assert fifo_rd for exactly one cycle;
//      - load fifo_r_data into the shift register;
//      - clear the tick counter s_cnt;
//      - go to START. tx drives 0 from the next clk edge.
//  - Tick counting: s_cnt increments only on s_tick. Each bit period ends on the s_tick where s_cnt==15.
//    At that point s_cnt returns to 0.
//  - START: tx=0 for 16 ticks, then go to DATA with bit counter n_cnt=0.
//  - DATA: tx=shreg[0] for 16 ticks. At the end of the bit, shreg is shifted right and n_cnt increments.
//    After bit DBIT-1, go to PARITY (macro defined) or STOP.
//  - STOP: tx=1. The state ends on the s_tick where s_cnt==SB_TICK-1. On that tick:
//      - pulse tx_done_tick;
//      - go to IDLE.
//  - Back-to-back frames: if the FIFO is non-empty on return to IDLE, the next pop happens on the first IDLE clk.
//    The inter-frame gap is therefore exactly one clk.
//  - Frame length: 16*(1+DBIT[+1]) + SB_TICK ticks.
//  - fifo_rd is never asserted while fifo_empty=1, and never more than once per frame.
//  - fifo_r_data and fifo_empty changes mid-frame are ignored; the byte is captured at pop.
//  - Reset mid-frame: tx returns to 1 asynchronously. The frame in flight is lost, with no re-pop.
//    Transmission resumes from IDLE with the next FIFO word.
//  - s_tick during IDLE is ignored. s_cnt is cleared on every IDLE->START transition.
// CONFIGURATION
//  - UART_TX_PARITY_EN defined:
//      - PARITY state inserted after DATA: tx = (^data) ^ par_odd for 16 ticks;
//      - the parity value is computed on the byte captured at pop;
//      - port par_odd is present.
//  - Not defined: no PARITY state, no par_odd port, frame = start+DBIT+stop.
// STRUCTURE
//  - Shared package uart_pkg:
//      - enum typedef tx_state_t {IDLE, START, DATA, PARITY, STOP}, with PARITY always declared;
//      - localparam OVERSAMPLE=16.
//  - Single module, no sub-module. The baud tick generator and the FIFO are external instances.
// TESTING  (DBIT=8, SB_TICK=16, s_tick every 4 clk)
//  1. Assert reset_n=0 with fifo_empty=0 -> tx=1, fifo_rd=0, tx_busy=0 throughout. No pop after release
//     until the first IDLE clk.
//  2. FIFO holds 0xA5 -> one fifo_rd pulse, then tx: 0 x16 ticks, 1,0,1,0,0,1,0,1 x16 ticks each,
//     1 x16 ticks. Exactly one tx_done_tick; 160 ticks total.
//  3. FIFO holds 0x00 then 0xFF -> two fifo_rd pulses. The second start bit begins one clk after the
//     first tx_done_tick; tx_busy stays high except that one clk.
//  4. fifo_empty held 1 for 1000 clk -> fifo_rd never asserted, tx=1, tx_busy=0.
//  5. reset_n pulsed low during the DATA bit 3 of 0x3C, with 0x81 queued -> tx=1 immediately, 0x3C not resent.
//     The next frame carries 0x81.
//  6. UART_TX_PARITY_EN, 0x07, par_odd=0 -> parity bit 1, 176 ticks total. Same byte with par_odd=1 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
package uart_pkg;

  // PARITY is declared even in builds without parity so the encoding never shifts.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // s_tick pulses per bit period
  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter fed from a first-word-fall-through TX FIFO.
// Pops one word per frame and sends start, DBIT data bits LSB first,
// an optional parity bit and the stop period, timed by a 16x baud tick.
// Optional feature: define UART_TX_PARITY_EN to add the parity bit and par_odd port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, pops the FIFO head as soon as it is non-empty
// START  | start bit (tx=0) for one bit period
// DATA   | data bits, LSB first, one bit period each
// PARITY | parity bit ((^data) ^ par_odd), only with UART_TX_PARITY_EN
// STOP   | line high for SB_TICK ticks, pulses tx_done_tick at the end
module uart_tx_fifo_reader #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
`ifdef UART_TX_PARITY_EN
  input  logic            par_odd,
`endif
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  import uart_pkg::*;

  // s_cnt must hold both the bit period and the (possibly longer) stop period
  localparam int SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  tx_state_t       state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            armed_q;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // State, counters and registered line outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Holds off the first pop until one full clk after reset release, so the
  // FIFO is never popped while reset is still asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed_q <= 1'b0;
    else          armed_q <= 1'b1;
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the word captured at pop; par_odd is applied while it is sent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_q <= 1'b0;
    else          par_q <= par_d;
  end
`endif

  // Next-state, counter updates, pop strobe and next tx value
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    fifo_rd = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (armed_q && !fifo_empty) begin
          fifo_rd = 1'b1;
          shreg_d = fifo_r_data;
          s_cnt_d = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_r_data;
`endif
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            shreg_d = shreg_q >> 1;
            if (n_cnt_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            s_cnt_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM is going
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d ^ par_odd;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Self-checking bench for uart_tx_fifo_reader (DBIT=8, SB_TICK=16, s_tick every 4 clk).
// A FIFO model feeds the DUT; a line receiver decodes tx and compares each frame
// against the bytes written, in write order. Define UART_TX_PARITY_EN for the parity build.
module tb_uart_tx_fifo_reader;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int NB       = 16 * (1 + DBIT + PBITS) + SB_TICK;
  localparam int STOP_IDX = 1 + DBIT + PBITS;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            s_tick = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [DBIT-1:0] fifo_r_data = '0;
  logic            fifo_rd;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;
`ifdef UART_TX_PARITY_EN
  logic            par_odd = 1'b0;
`endif

  uart_tx_fifo_reader #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_rd      (fifo_rd),
`ifdef UART_TX_PARITY_EN
    .par_odd      (par_odd),
`endif
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // one-clk baud tick every 4 clk
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [DBIT-1:0] push_q[$];
  logic [DBIT-1:0] exp_q[$];
  logic [DBIT-1:0] fifo_q[$];
  int push_rd  = 0;
  int pop_cnt  = 0;
  int n_pushed = 0;
  logic rd_seen = 1'b0;

  always @(negedge clk) rd_seen = fifo_rd;

  always @(posedge clk) begin
    #1;
    if (rd_seen) begin
      check("rd_only_when_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pop_cnt++;
    end
    while (push_rd < push_q.size()) begin
      fifo_q.push_back(push_q[push_rd]);
      push_rd++;
    end
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  task automatic push(input logic [DBIT-1:0] b);
    push_q.push_back(b);
    exp_q.push_back(b);
    n_pushed++;
  endtask

  // ---------------- line receiver / scoreboard ----------------
  bit              mon_active = 0;
  int              mon_k      = 0;
  int              mon_err    = 0;
  logic [DBIT-1:0] mon_exp    = '0;
  logic [DBIT-1:0] mon_rx     = '0;
  logic            mon_par    = 1'b0;
  int              exp_rd     = 0;
  int              pop_mark   = 0;
  int              done_cnt   = 0;
  int              idle_bad   = 0;
  bit              b2b_pend   = 0;

  function automatic logic frame_bit(input logic [DBIT-1:0] b, input logic p, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DBIT) return b[idx-1];
    if (PBITS == 1 && idx == DBIT + 1) return p;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    int idx;
    if (!reset_n) begin
      mon_active = 0;
      b2b_pend   = 0;
      pop_mark   = pop_cnt;
    end else begin
      if (b2b_pend) begin
        check("b2b_start_after_one_clk", 32'(tx), 32'd0);
        b2b_pend = 0;
      end
      if (!mon_active) begin
        if (tx === 1'b0) begin
          check("frame_was_expected", 32'(exp_rd < exp_q.size()), 32'd1);
          check("one_pop_per_frame", 32'(pop_cnt - pop_mark), 32'd1);
          pop_mark = pop_cnt;
          mon_exp  = (exp_rd < exp_q.size()) ? exp_q[exp_rd] : '0;
          exp_rd++;
`ifdef UART_TX_PARITY_EN
          mon_par  = (^mon_exp) ^ par_odd;
`else
          mon_par  = 1'b0;
`endif
          mon_active = 1;
          mon_k      = 0;
          mon_err    = 0;
          mon_rx     = '0;
        end else if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) begin
          idle_bad++;
        end
      end
      if (mon_active) begin
        if (tx_done_tick === 1'b1) begin
          check("frame_ticks", 32'(mon_k), 32'(NB));
          check("frame_bits", 32'(mon_err), 32'd0);
          check("rx_byte", 32'(mon_rx), 32'(mon_exp));
          check("busy_low_on_done", 32'(tx_busy), 32'd0);
          done_cnt++;
          mon_active = 0;
          if (!fifo_empty) b2b_pend = 1;
        end else begin
          idx = mon_k / 16;
          if (idx > STOP_IDX) idx = STOP_IDX;
          if (tx !== frame_bit(mon_exp, mon_par, idx)) mon_err++;
          if (tx_busy !== 1'b1) mon_err++;
          if (s_tick) begin
            if ((mon_k % 16) == 8 && idx >= 1 && idx <= DBIT) mon_rx[idx-1] = tx;
            mon_k++;
            if (mon_k > NB + 32) begin
              check("done_within_frame", 32'(mon_k), 32'(NB));
              mon_active = 0;
            end
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (!(exp_rd == exp_q.size() && !mon_active && push_rd == push_q.size()
             && fifo_q.size() == 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(c < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int cnt_rd, cnt_tx, cnt_busy, p0, c;

    // reset held with a word waiting in the FIFO
    reset_n = 1'b0;
    push(8'h5A);
    repeat (10) begin
      @(negedge clk);
      check("reset_outputs", 32'({tx, fifo_rd, tx_busy}), 32'b100);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    #1 check("no_pop_at_release", 32'(fifo_rd), 32'd0);
    wait_drain("drain_after_reset", 2000);

    // single frame 0xA5
    d0 = done_cnt;
    push(8'hA5);
    wait_drain("drain_a5", 2000);
    check("a5_one_done", 32'(done_cnt - d0), 32'd1);

    // back-to-back 0x00, 0xFF
    d0 = done_cnt;
    push(8'h00);
    push(8'hFF);
    wait_drain("drain_b2b", 3000);
    check("b2b_two_done", 32'(done_cnt - d0), 32'd2);

    // FIFO empty for 1000 clk
    cnt_rd = 0; cnt_tx = 0; cnt_busy = 0; p0 = pop_cnt;
    repeat (1000) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0) cnt_rd++;
      if (tx !== 1'b1) cnt_tx++;
      if (tx_busy !== 1'b0) cnt_busy++;
    end
    check("empty_no_rd", 32'(cnt_rd), 32'd0);
    check("empty_tx_high", 32'(cnt_tx), 32'd0);
    check("empty_not_busy", 32'(cnt_busy), 32'd0);
    check("empty_no_pops", 32'(pop_cnt - p0), 32'd0);

    // reset during data bit 3 of 0x3C with 0x81 queued
    d0 = done_cnt;
    push(8'h3C);
    push(8'h81);
    c = 0;
    while (!(mon_active && mon_k >= 72) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("reached_data_bit3", 32'(c < 2000), 32'd1);
    #1 reset_n = 1'b0;
    #1 check("reset_async_tx", 32'(tx), 32'd1);
    check("reset_async_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    wait_drain("drain_after_midreset", 3000);
    check("midreset_one_done", 32'(done_cnt - d0), 32'd1);

`ifdef UART_TX_PARITY_EN
    // parity: 0x07 even then odd
    par_odd = 1'b0;
    push(8'h07);
    wait_drain("drain_par_even", 2000);
    par_odd = 1'b1;
    push(8'h07);
    wait_drain("drain_par_odd", 2000);
    par_odd = 1'b0;
`endif

    // random traffic with random gaps
    for (int i = 0; i < 12; i++) begin
      push(8'($urandom));
      if ($urandom_range(0, 3) == 0) push(8'($urandom));
      repeat ($urandom_range(0, 700)) @(negedge clk);
    end
    wait_drain("drain_random", 20000);

    // one frame was cut by reset; every other pushed byte completes
    check("total_done", 32'(done_cnt), 32'(n_pushed - 1));
    check("idle_line_clean", 32'(idle_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
